// File: rtl/ps2_pkg.sv
// ps2_pkg: shared receiver state encoding and default timing constants.
package ps2_pkg;
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    localparam int FILTER_LEN_DEF     = 4;
    localparam int TIMEOUT_CYCLES_DEF = 100000;
endpackage

// File: rtl/ps2_filter.sv
// ps2_filter: synchronizes PS2_CLK/PS2_DAT, debounces the clock and flags its falling edges.
module ps2_filter import ps2_pkg::*; #(
    parameter int FILTER_LEN = FILTER_LEN_DEF
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic PS2_CLK,
    input  logic PS2_DAT,
    output logic sample,
    output logic dat
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    logic [1:0]    clk_s, dat_s;
    logic          filt;
    logic [FW-1:0] run;
    // run counts consecutive synchronized samples that disagree with the filtered level
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            clk_s  <= '1;
            dat_s  <= '1;
            filt   <= 1'b1;
            run    <= '0;
            sample <= 1'b0;
        end else begin
            clk_s  <= {clk_s[0], PS2_CLK};
            dat_s  <= {dat_s[0], PS2_DAT};
            sample <= 1'b0;
            if (clk_s[1] == filt)
                run <= '0;
            else if (run == FW'(FILTER_LEN - 1)) begin
                filt   <= clk_s[1];
                run    <= '0;
                sample <= filt;
            end else
                run <= run + FW'(1);
        end
    end
    assign dat = dat_s[1];
endmodule

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 keyboard frame receiver with odd-parity check, timeout and one-byte holding register.
module ps2_rx import ps2_pkg::*; #(
    parameter int FILTER_LEN     = FILTER_LEN_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    input  logic       rd,
    output logic [7:0] data,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    state_t        state, state_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shift, shift_n;
    logic          par, par_n;
    logic [CW-1:0] cnt;
    logic          sample, sdat, timeout, accept, perr_n, ferr_n;

    ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .CLOCK_50(CLOCK_50),
        .reset(reset),
        .PS2_CLK(PS2_CLK),
        .PS2_DAT(PS2_DAT),
        .sample(sample),
        .dat(sdat)
    );

    assign timeout = (state != IDLE) && (cnt == CW'(TIMEOUT_CYCLES));
    assign busy    = state != IDLE;

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        par_n     = par;
        accept    = 1'b0;
        perr_n    = 1'b0;
        ferr_n    = 1'b0;
        if (timeout) begin
            state_n = IDLE;
            ferr_n  = 1'b1;
        end else if (sample) begin
            case (state)
                IDLE: begin
                    state_n   = sdat ? IDLE : DATA;
                    bit_cnt_n = 3'd0;
                end
                DATA: begin
                    shift_n   = {sdat, shift[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    state_n   = (bit_cnt == 3'd7) ? PARITY : DATA;
                end
                PARITY: begin
                    par_n   = sdat;
                    state_n = STOP;
                end
                STOP: begin
                    state_n = IDLE;
                    ferr_n  = ~sdat;
                    perr_n  = sdat & ~(^shift ^ par);
                    accept  = sdat & (^shift ^ par);
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            par        <= 1'b0;
            cnt        <= '0;
            data       <= '0;
            valid      <= 1'b0;
            overrun    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shift      <= shift_n;
            par        <= par_n;
            parity_err <= perr_n;
            frame_err  <= ferr_n;
            cnt        <= (state == IDLE || sample || timeout) ? '0 :
                          (cnt == CW'(TIMEOUT_CYCLES)) ? cnt : cnt + CW'(1);
            // a consumer read in the accept cycle frees the slot, so the new byte replaces the old
            data       <= (accept && (!valid || rd)) ? shift : data;
            valid      <= accept ? 1'b1 : (rd && valid) ? 1'b0 : valid;
            overrun    <= accept ? ((valid && !rd) ? 1'b1 : overrun) :
                          (rd && valid) ? 1'b0 : overrun;
        end
    end
endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: drives PS/2 frames (directed and random) and checks against a holding-register model.
module tb_ps2_rx;
    localparam int FLEN = 4;
    localparam int TO   = 300;
    localparam int HALF = 40;

    logic       CLOCK_50 = 0, reset = 1, PS2_CLK = 1, PS2_DAT = 1, rd = 0;
    logic [7:0] data;
    logic       valid, parity_err, frame_err, overrun, busy;

    int total = 0, bad = 0;
    int perr_seen = 0, ferr_seen = 0, both_seen = 0;
    int exp_perr = 0, exp_ferr = 0;
    logic [7:0] m_data = 0;
    bit m_valid = 0, m_ovr = 0;

    ps2_rx #(.FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TO)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT), .rd(rd),
        .data(data), .valid(valid), .parity_err(parity_err), .frame_err(frame_err),
        .overrun(overrun), .busy(busy)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(negedge CLOCK_50) if (!reset) begin
        perr_seen += int'(parity_err);
        ferr_seen += int'(frame_err);
        both_seen += int'(parity_err & frame_err);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".data"}, 32'(data), 32'(m_data));
        chk({tag, ".valid"}, 32'(valid), 32'(m_valid));
        chk({tag, ".overrun"}, 32'(overrun), 32'(m_ovr));
        chk({tag, ".perr"}, 32'(perr_seen), 32'(exp_perr));
        chk({tag, ".ferr"}, 32'(ferr_seen), 32'(exp_ferr));
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic do_rd();
        tick(1);
        rd = 1;
        tick(1);
        rd = 0;
        if (m_valid) begin
            m_valid = 0;
            m_ovr   = 0;
        end
        tick(2);
    endtask

    task automatic do_reset();
        reset = 1;
        tick(3);
        reset = 0;
        m_data = 0; m_valid = 0; m_ovr = 0;
        tick(2);
    endtask

    // frame bits LSB first: start, 8 data, odd parity, stop; rd_acc pulses rd in the accept cycle
    task automatic send(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                        input int nbits, input bit rd_acc);
        logic [10:0] f;
        f = {~bad_stop, ~(^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            PS2_DAT = f[i];
            tick(HALF);
            PS2_CLK = 0;
            if (rd_acc && i == 10) begin
                tick(2 + FLEN);
                rd = 1;
                tick(1);
                rd = 0;
                tick(HALF - 3 - FLEN);
            end else
                tick(HALF);
            PS2_CLK = 1;
        end
        tick(HALF);
        PS2_DAT = 1;
        tick(HALF);
        if (nbits == 11) begin
            if (bad_stop) exp_ferr++;
            else if (bad_par) exp_perr++;
            else if (!m_valid) begin m_data = b; m_valid = 1; end
            else if (rd_acc) m_data = b;
            else m_ovr = 1;
        end
    endtask

    initial begin
        logic [7:0] b;
        int kind;
        tick(3);
        reset = 0;
        tick(2);
        chk("reset.busy", 32'(busy), 0);
        check_all("reset");

        send(8'h1C, 0, 0, 11, 0);
        check_all("good1C");
        do_rd();
        chk("good1C.rd_valid", 32'(valid), 0);

        send(8'h1C, 1, 0, 11, 0);
        check_all("badpar");

        send(8'hF0, 0, 0, 11, 0);
        send(8'h1C, 0, 0, 11, 0);
        check_all("overrun");
        do_rd();
        check_all("overrun.rd");

        send(8'h33, 0, 0, 4, 0);
        chk("timeout.busy_before", 32'(busy), 1);
        tick(TO + 20);
        exp_ferr++;
        chk("timeout.busy", 32'(busy), 0);
        check_all("timeout");
        send(8'h1C, 0, 0, 11, 0);
        check_all("after_timeout");
        do_rd();

        send(8'h1C, 0, 1, 11, 0);
        check_all("badstop");

        send(8'hF0, 0, 0, 11, 0);
        send(8'h1C, 0, 0, 11, 1);
        check_all("rd_at_accept");
        do_rd();

        send(8'hA5, 0, 0, 6, 0);
        do_reset();
        check_all("midreset");
        send(8'h5A, 0, 0, 11, 0);
        check_all("after_reset5A");
        do_rd();

        for (int n = 0; n < 30; n++) begin
            b    = 8'($urandom);
            kind = int'($urandom_range(0, 5));
            send(b, kind == 0, kind == 1, 11, 0);
            check_all($sformatf("rand%0d", n));
            if ($urandom_range(0, 1) == 1) do_rd();
        end

        chk("never_both", 32'(both_seen), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
